// File: rtl/dbd_ctrl_pkg.sv
// dbd_ctrl_pkg
// Shared definitions for the backlight-dimming pass-through controller:
// pass-stage FSM state codes, default geometry widths, lock depth and a
// saturating increment helper for the frame-match counter.

package dbd_ctrl_pkg;

   // Pass-stage state codes; the numeric values are visible on oState
   typedef enum logic [1:0] {
      ST_BLANK = 2'd0,
      ST_ARMED = 2'd1,
      ST_PASS  = 2'd2,
      ST_DRAIN = 2'd3
   } passState_t;

   localparam int unsigned DEF_H_W         = 12;
   localparam int unsigned DEF_V_W         = 11;
   localparam int unsigned DEF_LOCK_FRAMES = 2;
   localparam int unsigned DEF_TO_W        = 22;

   // Wide enough for any lock depth from 1 to 15
   localparam int unsigned MATCH_W = 4;

   // Counts up by one but never past the given limit
   function automatic logic [MATCH_W-1:0] satInc(input logic [MATCH_W-1:0] value,
                                                 input logic [MATCH_W-1:0] limit);
      if (value >= limit) begin
         return limit;
      end
      return value + 1'b1;
   endfunction

endpackage

// File: rtl/frame_geom_meas.sv
// frame_geom_meas
// Measures active frame geometry from DE/VSYNC and decides whether the
// incoming timing is stable. It produces the frame-start pulse, the width
// and height of the last complete frame, and the lock flag. The lock flag
// is also offered one cycle early so the pass FSM can leave PASS on the
// same edge that lock drops.

module frame_geom_meas
   import dbd_ctrl_pkg::*;
#(
   parameter int unsigned H_W         = DEF_H_W,
   parameter int unsigned V_W         = DEF_V_W,
   parameter int unsigned LOCK_FRAMES = DEF_LOCK_FRAMES
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_de,
   input  logic           i_hsync,
   input  logic           i_vsync,
   input  logic           i_clrMatch,
   output logic           o_fs,
   output logic [H_W-1:0] o_width,
   output logic [V_W-1:0] o_height,
   output logic           o_locked,
   output logic           o_lockNext
);

   localparam logic [MATCH_W-1:0] LOCK_CODE = MATCH_W'(LOCK_FRAMES);

   logic               r_deDly;
   logic               r_vsDly;
   logic [H_W-1:0]     r_pixCnt;
   logic [H_W-1:0]     r_firstWidth;
   logic [V_W-1:0]     r_lineCnt;
   logic               r_irregular;
   logic [H_W-1:0]     r_width;
   logic [V_W-1:0]     r_height;
   logic [MATCH_W-1:0] r_matchCnt;
   logic               r_locked;

   logic               w_fs;
   logic               w_lineEnd;
   logic               w_frameMatch;
   logic [MATCH_W-1:0] w_matchNext;
   logic               w_lockNext;

   assign w_fs      = i_vsync & ~r_vsDly;
   assign w_lineEnd = r_deDly & ~i_de;

   // A frame counts as a match only if every line had the same width, it had
   // at least one line, and it repeats the geometry captured one frame earlier
   assign w_frameMatch = ~r_irregular && (r_lineCnt != '0) &&
                         (r_firstWidth == r_width) && (r_lineCnt == r_height);

   // Next match count: watchdog clear wins, otherwise updated only at frame start
   always_comb begin
      w_matchNext = r_matchCnt;
      if (i_clrMatch) begin
         w_matchNext = '0;
      end else if (w_fs) begin
         w_matchNext = w_frameMatch ? satInc(r_matchCnt, LOCK_CODE) : '0;
      end
   end

   assign w_lockNext = (w_matchNext == LOCK_CODE);

   // Single registration of DE and VSYNC for edge detection
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_deDly <= 1'b0;
         r_vsDly <= 1'b0;
      end else begin
         r_deDly <= i_de;
         r_vsDly <= i_vsync;
      end
   end

   // Active-pixel counter for the current line; held at zero in blanking
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pixCnt <= '0;
      end else if (w_fs || w_lineEnd) begin
         r_pixCnt <= '0;
      end else if (i_de) begin
         if (!(&r_pixCnt)) begin
            r_pixCnt <= r_pixCnt + 1'b1;
         end
      end else if (i_hsync) begin
         r_pixCnt <= '0;
      end
   end

   // Per-frame line count, first-line width and irregular-width flag
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_lineCnt    <= '0;
         r_firstWidth <= '0;
         r_irregular  <= 1'b0;
      end else if (w_fs) begin
         r_lineCnt    <= '0;
         r_firstWidth <= '0;
         r_irregular  <= 1'b0;
      end else if (w_lineEnd) begin
         if (r_lineCnt == '0) begin
            r_firstWidth <= r_pixCnt;
         end else if (r_pixCnt != r_firstWidth) begin
            r_irregular <= 1'b1;
         end
         if (!(&r_lineCnt)) begin
            r_lineCnt <= r_lineCnt + 1'b1;
         end
      end
   end

   // Capture the finished frame's geometry and update the lock state
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_width    <= '0;
         r_height   <= '0;
         r_matchCnt <= '0;
         r_locked   <= 1'b0;
      end else begin
         if (w_fs) begin
            r_width  <= r_firstWidth;
            r_height <= r_lineCnt;
         end
         r_matchCnt <= w_matchNext;
         r_locked   <= w_lockNext;
      end
   end

   assign o_fs       = w_fs;
   assign o_width    = r_width;
   assign o_height   = r_height;
   assign o_locked   = r_locked;
   assign o_lockNext = w_lockNext;

endmodule

// File: rtl/frame_pass_ctrl.sv
// frame_pass_ctrl
// Controls the pass enable of the video pass-through stage in the backlight
// dimming path. Pass/blank switching is aligned to frame starts; only a loss
// of timing lock can force blanking mid-frame.
// Build option: define FRAME_TIMEOUT_EN to add a VSYNC watchdog that drops
// lock when no frame start arrives within 2**TO_W - 1 cycles.

module frame_pass_ctrl
   import dbd_ctrl_pkg::*;
#(
   parameter int unsigned H_W         = DEF_H_W,
   parameter int unsigned V_W         = DEF_V_W,
   parameter int unsigned LOCK_FRAMES = DEF_LOCK_FRAMES,
   parameter int unsigned TO_W        = DEF_TO_W
) (
   input  logic           iODCK,
   input  logic           iRST,
   input  logic           iDE,
   input  logic           iHSYNC,
   input  logic           iVSYNC,
   input  logic           iPassReq,
   output logic           oPassEn,
   output logic           oLocked,
   output logic [H_W-1:0] oActWidth,
   output logic [V_W-1:0] oActHeight,
   output logic [7:0]     oFrameCnt,
   output logic [1:0]     oState
);

   passState_t r_state;
   passState_t w_nextState;
   logic       r_passEn;
   logic [7:0] r_frameCnt;

   logic       w_fs;
   logic       w_locked;
   logic       w_lockNext;
   logic       w_toExpire;
   logic       w_passEnNext;

   frame_geom_meas #(
      .H_W        (H_W),
      .V_W        (V_W),
      .LOCK_FRAMES(LOCK_FRAMES)
   ) u_meas (
      .i_clk      (iODCK),
      .i_rst      (iRST),
      .i_de       (iDE),
      .i_hsync    (iHSYNC),
      .i_vsync    (iVSYNC),
      .i_clrMatch (w_toExpire),
      .o_fs       (w_fs),
      .o_width    (oActWidth),
      .o_height   (oActHeight),
      .o_locked   (w_locked),
      .o_lockNext (w_lockNext)
   );

`ifdef FRAME_TIMEOUT_EN
   logic [TO_W-1:0] r_wdog;

   // Watchdog restarts on every frame start and parks at all-ones on expiry
   always_ff @(posedge iODCK or posedge iRST) begin
      if (iRST) begin
         r_wdog <= '0;
      end else if (w_fs) begin
         r_wdog <= '0;
      end else if (!(&r_wdog)) begin
         r_wdog <= r_wdog + 1'b1;
      end
   end

   assign w_toExpire = &r_wdog;
`else
   logic [TO_W-1:0] w_wdog;

   assign w_wdog     = '0;
   assign w_toExpire = &w_wdog;
`endif

   // Free-running frame-start counter, wraps naturally at 8 bits
   always_ff @(posedge iODCK or posedge iRST) begin
      if (iRST) begin
         r_frameCnt <= '0;
      end else if (w_fs) begin
         r_frameCnt <= r_frameCnt + 1'b1;
      end
   end

   // Pass FSM next state; lock decisions use the value lock takes this edge
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_BLANK: begin
            if (iPassReq && w_lockNext) begin
               w_nextState = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (!iPassReq) begin
               w_nextState = ST_BLANK;
            end else if (w_fs && w_lockNext) begin
               w_nextState = ST_PASS;
            end
         end
         ST_PASS: begin
            if (!w_lockNext) begin
               w_nextState = ST_BLANK;
            end else if (!iPassReq) begin
               w_nextState = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!w_lockNext) begin
               w_nextState = ST_BLANK;
            end else if (iPassReq) begin
               w_nextState = ST_PASS;
            end else if (w_fs) begin
               w_nextState = ST_BLANK;
            end
         end
         default: begin
            w_nextState = ST_BLANK;
         end
      endcase
   end

   assign w_passEnNext = (w_nextState == ST_PASS) || (w_nextState == ST_DRAIN);

   // State register and pass enable, both updated on the transition edge
   always_ff @(posedge iODCK or posedge iRST) begin
      if (iRST) begin
         r_state  <= ST_BLANK;
         r_passEn <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_passEn <= w_passEnNext;
      end
   end

   assign oPassEn   = r_passEn;
   assign oLocked   = w_locked;
   assign oFrameCnt = r_frameCnt;
   assign oState    = r_state;

endmodule
